// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, timeout default and FSM state encoding for ifetch
package ifetch_pkg;

    localparam int XLEN               = 32;
    localparam int ADDR_W             = 32;
    localparam int IFETCH_TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HOLD = 3'd2,
        ST_DROP = 3'd3,
        ST_ERR  = 3'd4
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_tmr.sv
// rtl/ifetch_tmr.sv - counts unacknowledged request cycles, flags when LIMIT is reached
module ifetch_tmr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Fires in the LIMIT-th consecutive unacked cycle so the request drops right after it.
    assign expired = count_en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch FSM; define IFETCH_TIMEOUT_EN to enable the request timeout
module ifetch
    import ifetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = IFETCH_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              addr_valid,
    output logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              fetch_err
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] REQ  = ST_REQ;
    localparam logic [2:0] HOLD = ST_HOLD;
    localparam logic [2:0] DROP = ST_DROP;
    localparam logic [2:0] ERR  = ST_ERR;

    logic [2:0] state;
    logic       tmo_expired;

`ifdef IFETCH_TIMEOUT_EN
    logic tmo_count;

    assign tmo_count = ((state == REQ) || (state == DROP)) && !imem_ack;

    ifetch_tmr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (tmo_count),
        .expired  (tmo_expired)
    );
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYC;
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            fetch_en  <= 1'b0;
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc     <= '0;
            fetch_err <= 1'b0;
        end else begin
            fetch_en <= 1'b0;
            if (tmo_expired) begin
                state     <= ERR;
                imem_req  <= 1'b0;
                id_valid  <= 1'b0;
                fetch_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (addr_valid && !flush) begin
                            imem_req  <= 1'b1;
                            imem_addr <= i_address;
                            state     <= REQ;
                        end
                    end
                    REQ: begin
                        // A flushed request still owns the bus until memory acks it.
                        if (flush) begin
                            if (imem_ack) begin
                                imem_req <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state <= DROP;
                            end
                        end else if (imem_ack) begin
                            id_instr <= imem_rdata;
                            id_pc    <= imem_addr;
                            id_valid <= 1'b1;
                            imem_req <= 1'b0;
                            fetch_en <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (flush) begin
                            id_valid <= 1'b0;
                            state    <= IDLE;
                        end else if (id_ready) begin
                            id_valid <= 1'b0;
                            if (addr_valid) begin
                                imem_req  <= 1'b1;
                                imem_addr <= i_address;
                                state     <= REQ;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
